// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: divider FSM states, widths and the divide-by-zero quotient.
package cpu_defs_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 5;

  localparam logic [DIV_WIDTH-1:0] DIV0_QUOT = {DIV_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor and keep the difference when it is non-negative.
module div_step
  import cpu_defs_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] trial_s;

  // rem < div always holds, so a non-negative trial never sets the top bit.
  always_comb begin
    shifted_s = {rem_i, quo_i[WIDTH-1]};
    trial_s   = shifted_s - {1'b0, div_i};
    if (trial_s[WIDTH]) begin
      rem_o = shifted_s[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end else begin
      rem_o = trial_s[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; stalls the pipeline while
// running and produces {remainder, quotient} for hi/lo.
module div_unit
  import cpu_defs_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               cancel,
  output logic               div_stall,
  output logic               valid,
  output logic [2*WIDTH-1:0] result
);

  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   div_q, div_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic [WIDTH-1:0]   a_mag_s;
  logic [WIDTH-1:0]   b_mag_s;
  logic [WIDTH-1:0]   step_rem_s;
  logic [WIDTH-1:0]   step_quo_s;
  logic [WIDTH-1:0]   fix_rem_s;
  logic [WIDTH-1:0]   fix_quo_s;
  logic               b_zero_s;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (div_q),
    .rem_o (step_rem_s),
    .quo_o (step_quo_s)
  );

  always_comb begin
    a_mag_s   = (signed_div && a[WIDTH-1]) ? -a : a;
    b_mag_s   = (signed_div && b[WIDTH-1]) ? -b : b;
    b_zero_s  = (b == {WIDTH{1'b0}});
    fix_quo_s = neg_quo_q ? -step_quo_s : step_quo_s;
    fix_rem_s = neg_rem_q ? -step_rem_s : step_rem_s;
  end

  // Result is loaded on the edge into DONE so it is stable while valid is high.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    case (state_q)
      IDLE: begin
        if (start && !cancel) begin
          cnt_d     = {CNT_W{1'b0}};
          rem_d     = {WIDTH{1'b0}};
          neg_quo_d = signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem_d = signed_div & a[WIDTH-1];
          if (b_zero_s) begin
            quo_d    = a;
            div_d    = b;
            result_d = {a, DIV0_QUOT};
            state_d  = DONE;
          end else begin
            quo_d    = a_mag_s;
            div_d    = b_mag_s;
            state_d  = RUN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (cancel) begin
          state_d = IDLE;
        end else begin
          rem_d = step_rem_s;
          quo_d = step_quo_s;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            result_d = {fix_rem_s, fix_quo_s};
            state_d  = DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      rem_q     <= {WIDTH{1'b0}};
      quo_q     <= {WIDTH{1'b0}};
      div_q     <= {WIDTH{1'b0}};
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= {(2*WIDTH){1'b0}};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      div_q     <= div_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  // Stall drops in DONE so the divide instruction leaves E in the valid cycle.
  always_comb begin
    div_stall = ((state_q == IDLE) && start && !cancel && !b_zero_s) || (state_q == RUN);
    valid     = (state_q == DONE) && !cancel;
    result    = result_q;
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: vector table with a result scoreboard plus
// hand-written cancel, reset and back-to-back sequences.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        div_stall;
  logic        valid;
  logic [63:0] result;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_exp = 64'd0;

  typedef struct {
    logic        sgn;
    logic [31:0] va;
    logic [31:0] vb;
    logic [63:0] res;
    int          lat;
    int          stalls;
  } vec_t;

  vec_t vecs[11];

  div_unit dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .a          (a),
    .b          (b),
    .cancel     (cancel),
    .div_stall  (div_stall),
    .valid      (valid),
    .result     (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got valid=1 with result %h expected no valid", result);
      end else begin
        last_exp = exp_q.pop_front();
        chk("result", result, last_exp);
      end
    end
  end

  // Entered and left at #1 after a rising edge; start is held while div_stall is high.
  task automatic run_div(input logic sgn, input logic [31:0] da, input logic [31:0] db,
                         input logic [63:0] exp, input int exp_lat, input int exp_stall);
    int   stalls;
    int   lat;
    logic st;
    stalls = 0;
    lat    = -1;
    signed_div = sgn;
    a          = da;
    b          = db;
    start      = 1'b1;
    exp_q.push_back(exp);
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      st = div_stall;
      if (st) stalls++;
      if (valid) begin
        lat = t;
        break;
      end
      @(posedge clk);
      #1;
      if (!st) start = 1'b0;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("stall_cycles", 64'(stalls), 64'(exp_stall));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_stall", {63'd0, div_stall}, 64'd0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    vecs[0]  = '{1'b0, 32'd100,        32'd7,          {32'd2,          32'd14},         33, 33};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF,   32'hFFFFFFFD},   33, 33};
    vecs[2]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'h00000000,   32'h80000000},   33, 33};
    vecs[3]  = '{1'b0, 32'h00001234,   32'd0,          {32'h00001234,   32'hFFFFFFFF},   1,  0};
    vecs[4]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          {32'd0,          32'hFFFFFFFF},   33, 33};
    vecs[5]  = '{1'b0, 32'd5,          32'hFFFFFFFF,   {32'd5,          32'd0},          33, 33};
    vecs[6]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   {32'd1,          32'hFFFFFFFD},   33, 33};
    vecs[7]  = '{1'b1, 32'hFFFFFFF0,   32'd0,          {32'hFFFFFFF0,   32'hFFFFFFFF},   1,  0};
    vecs[8]  = '{1'b0, 32'hDEADBEEF,   32'h10,         {32'h0000000F,   32'h0DEADBEE},   33, 33};
    vecs[9]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   {32'hFFFFFFFE,   32'h0000000E},   33, 33};
    vecs[10] = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   {32'h80000000,   32'h00000000},   33, 33};

    rst = 1'b1; start = 1'b0; signed_div = 1'b0; a = 32'd0; b = 32'd0; cancel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_stall",  {63'd0, div_stall}, 64'd0);
    chk("reset_valid",  {63'd0, valid},     64'd0);
    chk("reset_result", result,             64'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++)
      run_div(vecs[i].sgn, vecs[i].va, vecs[i].vb, vecs[i].res, vecs[i].lat, vecs[i].stalls);

    // Cancel in RUN: back to IDLE, no valid, result untouched, then a fresh 9/3.
    signed_div = 1'b0; a = 32'd100; b = 32'd7; start = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    cancel = 1'b1; start = 1'b0;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    @(negedge clk);
    chk("cancel_run_stall",  {63'd0, div_stall}, 64'd0);
    chk("cancel_run_result", result,             last_exp);
    @(posedge clk);
    #1;
    idle_cycles(40);
    run_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 33);

    // start together with cancel in IDLE is ignored.
    a = 32'd50; b = 32'd5; start = 1'b1; cancel = 1'b1;
    @(negedge clk);
    chk("start_cancel_stall", {63'd0, div_stall}, 64'd0);
    @(posedge clk);
    #1;
    start = 1'b0; cancel = 1'b0;
    idle_cycles(5);

    // Cancel during DONE suppresses the valid pulse.
    a = 32'd100; b = 32'd7; start = 1'b1;
    repeat (33) @(posedge clk);
    #1;
    cancel = 1'b1;
    @(negedge clk);
    chk("cancel_done_valid", {63'd0, valid},     64'd0);
    chk("cancel_done_stall", {63'd0, div_stall}, 64'd0);
    @(posedge clk);
    #1;
    cancel = 1'b0; start = 1'b0;
    idle_cycles(3);

    // Reset during RUN: IDLE next edge with cleared outputs and no later valid.
    a = 32'd100; b = 32'd7; start = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1; start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_run_stall",  {63'd0, div_stall}, 64'd0);
    chk("rst_run_valid",  {63'd0, valid},     64'd0);
    chk("rst_run_result", result,             64'd0);
    @(posedge clk);
    #1;
    idle_cycles(40);

    // Back-to-back: second start lands in the IDLE cycle right after DONE.
    run_div(1'b0, 32'd9,  32'd3, {32'd0, 32'd3}, 33, 33);
    run_div(1'b0, 32'd10, 32'd4, {32'd2, 32'd2}, 33, 33);

    idle_cycles(2);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider in the execute stage for DIV/DIVU.
- Produces the 64-bit {remainder, quotient} pair written into the hilo register in MEM.
- Drives the stall that the hazard unit merges into stallF/stallD/stallE, holding the pipeline while a divide is in flight.
- Accepts a cancel from exception/flush logic.

Parameters:
- WIDTH, 32, operand width; quotient and remainder are each WIDTH bits.
- CNT_W, 5, iteration counter width; must equal clog2(WIDTH).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  divide instruction present in E stage (divE); level, held while stalled.
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- a  in  WIDTH  dividend (rs value after E-stage forwarding).
- b  in  WIDTH  divisor (rt value after E-stage forwarding).
- cancel  in  1  abort any in-flight divide (flushE/exception).
- div_stall  out  1  to hazard unit; high while the divide occupies E.
- valid  out  1  one-cycle pulse; result is final.
- result  out  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}; goes to hi/lo.

Behaviour:
- Reset: state = IDLE, counter = 0, all internal registers = 0. Outputs after reset: div_stall = 0, valid = 0, result = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE with start & !cancel:
  - Latch |a| and |b| (magnitudes only when signed_div), sign_q = a[msb]^b[msb] and sign_r = a[msb] (both only when signed_div), clear the partial remainder, counter = 0.
  - Next state is RUN, or DONE directly when b == 0.
- RUN: one restoring step per cycle (shift, trial subtract, keep on non-negative). At counter == WIDTH-1 the next state is DONE; otherwise the counter increments.
- DONE:
  - valid = 1 and result is registered; return to IDLE next cycle.
  - start is ignored in DONE, since the same instruction is still leaving E.
- div_stall is combinational: (IDLE & start & !cancel & b != 0) | RUN. It is low in DONE so the instruction advances the same cycle valid is high.
- Latency: nonzero divisor has start at T0, div_stall high T0..T32 (33 cycles), valid at T33. Zero divisor has no stall and valid at T1.
- Sign fix-up in DONE:
  - quotient negated when sign_q; remainder negated when sign_r.
  - -2^31 / -1 yields quotient 0x80000000, remainder 0, with no special case and no trap.
- Divide by zero: quotient = all-ones, remainder = a (unsigned, raw). ISA-undefined, but fixed here for deterministic verification.
- Cancel:
  - In RUN, cancel returns the FSM to IDLE next cycle, with no valid and result unchanged.
  - In DONE, cancel suppresses valid, so valid = DONE & !cancel.
  - start and cancel together in IDLE: start is ignored.
- result holds its last value until the next DONE and changes only in DONE.
- Reset asserted in any state forces IDLE on the next edge; no valid follows.
- Back-to-back divides: a second start is accepted in the IDLE cycle after DONE.

Decomposition:
- Shared package cpu_defs_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - DIV_WIDTH = 32 and DIV_CNT_W = 5;
  - DIV0_QUOT = all-ones.
- Natural sub-module: div_step, purely combinational, one restoring iteration. Inputs are the partial remainder, quotient, and divisor; outputs are the next partial remainder and quotient.
- The FSM, counter, and sign fix-up remain in div_unit.
- The hazard unit ORs div_stall into stallF/stallD/stallE. It does not flush E on div_stall.

Test Plan:
- DIVU a=100, b=7 -> div_stall high 33 cycles, valid at T33, result = {32'd2, 32'd14}.
- DIV a=-7 (0xFFFFFFF9), b=2 -> result = {0xFFFFFFFF, 0xFFFFFFFD} (r=-1, q=-3).
- DIV a=0x80000000, b=0xFFFFFFFF -> result = {0x00000000, 0x80000000}, no hang.
- DIVU a=0x1234, b=0 -> div_stall never high, valid at T1, result = {0x00001234, 0xFFFFFFFF}.
- DIVU 100/7 with cancel pulsed at T10 -> IDLE at T11, no valid, result unchanged. A new 9/3 then gives {0, 3} 33 cycles later.
- rst asserted at T15 of a running divide -> IDLE next edge, div_stall = 0, valid = 0, result = 0. Back-to-back 9/3 then 10/4 -> two valid pulses with results {0,3} and {2,2}.
